// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - sequences operand A, operand B and op-code entries into the ALU and captures its result
//
// Ports:
//   clk, resetn          clock; synchronous active-low reset
//   in_valid, in_value   one-cycle entry strobe and the entered value
//   sw_cin               carry-in switch, sampled when the op code is accepted
//   clear                synchronous abort back to S_A (keeps operands, result and counter)
//   op_a, op_b, op_code  ALU operand/op-select drive, stable for the whole of S_EXEC
//   op_cin               ALU carry-in drive
//   alu_out, alu_co      ALU result and carry-out inputs
//   res_value, res_co    captured result and carry, held until the next capture
//   res_valid            result belongs to the current operand set
//   err_op               last op-code entry was out of range
//   state_o              FSM state (S_A=0 S_B=1 S_OP=2 S_EXEC=3 S_DONE=4)
//   op_count             completed operations, saturating

module alu_operand_sequencer #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 3,
  parameter int NUM_OPS = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  input  logic             sw_cin,
  input  logic             clear,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [OPW-1:0]   op_code,
  output logic             op_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_co,
  output logic [WIDTH-1:0] res_value,
  output logic             res_co,
  output logic             res_valid,
  output logic             err_op,
  output logic [2:0]       state_o,
  output logic [15:0]      op_count
);

  // Latency counter only needs to reach ALU_LAT-1.
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0]    LP_CNT_LAST = CW'(ALU_LAT - 1);
  localparam logic [WIDTH-1:0] LP_NUM_OPS  = WIDTH'(NUM_OPS);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [OPW-1:0]   r_op_code;
  logic             r_op_cin;
  logic [WIDTH-1:0] r_res_value;
  logic             r_res_co;
  logic             r_res_valid;
  logic             r_err_op;
  logic [15:0]      r_op_count;

  // Range check uses the full entry width so e.g. 32'h100 is rejected
  // even though its low OPW bits look legal.
  logic w_op_ok;
  assign w_op_ok = (in_value < LP_NUM_OPS);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_A;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_code   <= '0;
      r_op_cin    <= 1'b0;
      r_res_value <= '0;
      r_res_co    <= 1'b0;
      r_res_valid <= 1'b0;
      r_err_op    <= 1'b0;
      r_op_count  <= '0;
    end else if (clear) begin
      // Abort only the sequencing; operands, result and counter survive.
      r_state     <= S_A;
      r_res_valid <= 1'b0;
      r_err_op    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_A: begin
          if (in_valid) begin
            r_op_a  <= in_value;
            r_state <= S_B;
          end
        end
        S_B: begin
          if (in_valid) begin
            r_op_b  <= in_value;
            r_state <= S_OP;
          end
        end
        S_OP: begin
          if (in_valid) begin
            if (w_op_ok) begin
              r_op_code <= in_value[OPW-1:0];
              r_op_cin  <= sw_cin;
              r_err_op  <= 1'b0;
              r_cnt     <= '0;
              r_state   <= S_EXEC;
            end else begin
              r_err_op  <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          // Entries are dropped here so the ALU inputs stay stable.
          if (r_cnt == LP_CNT_LAST) begin
            r_res_value <= alu_out;
            r_res_co    <= alu_co;
            r_res_valid <= 1'b1;
            if (r_op_count != 16'hFFFF) begin
              r_op_count <= r_op_count + 16'd1;
            end
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          // Chained entry: a new operand A starts the next operation.
          if (in_valid) begin
            r_op_a      <= in_value;
            r_res_valid <= 1'b0;
            r_state     <= S_B;
          end
        end
        default: begin
          r_state <= S_A;
        end
      endcase
    end
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign op_code   = r_op_code;
  assign op_cin    = r_op_cin;
  assign res_value = r_res_value;
  assign res_co    = r_res_co;
  assign res_valid = r_res_valid;
  assign err_op    = r_err_op;
  assign state_o   = r_state;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - self-checking bench for alu_operand_sequencer (ALU_LAT=1 and ALU_LAT=3 instances)

module tb_alu_operand_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_value = '0;
  logic        sw_cin = 1'b0;
  logic        clear = 1'b0;

  always #5 clk = ~clk;

  logic [31:0] a1, b1, out1, res1, a3, b3, out3, res3;
  logic [2:0]  code1, code3, st1, st3;
  logic        cin1, co1, rco1, rv1, err1, cin3, co3, rco3, rv3, err3;
  logic [15:0] cnt1, cnt3;

  // Bench ALU: op 0 adds with carry, every other op is a plain XOR.
  function automatic logic [32:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op, input logic cin);
    if (op == 3'd0) return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    return {1'b0, a ^ b};
  endfunction

  assign {co1, out1} = alu(a1, b1, code1, cin1);
  assign {co3, out3} = alu(a3, b3, code3, cin3);

  alu_operand_sequencer #(.WIDTH(32), .OPW(3), .NUM_OPS(8), .ALU_LAT(1)) u_lat1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_value(in_value),
    .sw_cin(sw_cin), .clear(clear), .op_a(a1), .op_b(b1), .op_code(code1),
    .op_cin(cin1), .alu_out(out1), .alu_co(co1), .res_value(res1), .res_co(rco1),
    .res_valid(rv1), .err_op(err1), .state_o(st1), .op_count(cnt1)
  );

  alu_operand_sequencer #(.WIDTH(32), .OPW(3), .NUM_OPS(8), .ALU_LAT(3)) u_lat3 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_value(in_value),
    .sw_cin(sw_cin), .clear(clear), .op_a(a3), .op_b(b3), .op_code(code3),
    .op_cin(cin3), .alu_out(out3), .alu_co(co3), .res_value(res3), .res_co(rco3),
    .res_valid(rv3), .err_op(err3), .state_o(st3), .op_count(cnt3)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: one entry per instance, index 0 -> ALU_LAT=1, 1 -> ALU_LAT=3.
  // phase: 0 waiting A, 1 waiting B, 2 waiting op, 3 executing, 4 result shown.
  int          m_lat   [2] = '{1, 3};
  int          m_phase [2];
  int          m_wait  [2];
  logic [31:0] m_a [2], m_b [2], m_res [2];
  logic [2:0]  m_code [2];
  logic        m_cin [2], m_co [2], m_rv [2], m_err [2];
  int          m_count [2];
  bit          m_ready = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        m_phase[i] = 0; m_wait[i] = 0; m_a[i] = 0; m_b[i] = 0; m_res[i] = 0;
        m_code[i] = 0; m_cin[i] = 0; m_co[i] = 0; m_rv[i] = 0; m_err[i] = 0;
        m_count[i] = 0;
      end else if (clear) begin
        m_phase[i] = 0; m_rv[i] = 0; m_err[i] = 0; m_wait[i] = 0;
      end else if (m_phase[i] == 3) begin
        m_wait[i] = m_wait[i] - 1;
        if (m_wait[i] == 0) begin
          {m_co[i], m_res[i]} = alu(m_a[i], m_b[i], m_code[i], m_cin[i]);
          m_rv[i] = 1'b1;
          if (m_count[i] < 65535) m_count[i] = m_count[i] + 1;
          m_phase[i] = 4;
        end
      end else if (in_valid) begin
        if (m_phase[i] == 0 || m_phase[i] == 4) begin
          m_a[i] = in_value; m_rv[i] = 1'b0; m_phase[i] = 1;
        end else if (m_phase[i] == 1) begin
          m_b[i] = in_value; m_phase[i] = 2;
        end else if (in_value < 32'd8) begin
          m_code[i] = in_value[2:0]; m_cin[i] = sw_cin; m_err[i] = 1'b0;
          m_wait[i] = m_lat[i]; m_phase[i] = 3;
        end else begin
          m_err[i] = 1'b1;
        end
      end
    end
    if (!resetn) m_ready = 1'b1;
  end

  // Every cycle after reset, both instances must agree with the model.
  always @(negedge clk) begin
    if (m_ready) begin
      chk("L1 state", st1, m_phase[0]);     chk("L3 state", st3, m_phase[1]);
      chk("L1 op_a", a1, m_a[0]);           chk("L3 op_a", a3, m_a[1]);
      chk("L1 op_b", b1, m_b[0]);           chk("L3 op_b", b3, m_b[1]);
      chk("L1 op_code", code1, m_code[0]);  chk("L3 op_code", code3, m_code[1]);
      chk("L1 op_cin", cin1, m_cin[0]);     chk("L3 op_cin", cin3, m_cin[1]);
      chk("L1 res_value", res1, m_res[0]);  chk("L3 res_value", res3, m_res[1]);
      chk("L1 res_co", rco1, m_co[0]);      chk("L3 res_co", rco3, m_co[1]);
      chk("L1 res_valid", rv1, m_rv[0]);    chk("L3 res_valid", rv3, m_rv[1]);
      chk("L1 err_op", err1, m_err[0]);     chk("L3 err_op", err3, m_err[1]);
      chk("L1 op_count", cnt1, m_count[0]); chk("L3 op_count", cnt3, m_count[1]);
    end
  end

  // One-cycle entry; returns #1 after the edge that consumed it.
  task automatic entry(input logic [31:0] v);
    in_valid = 1'b1; in_value = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    idle(2);
    resetn = 1'b1;
    // Reset state
    chk("rst state", st1, 0); chk("rst res_value", res1, 0); chk("rst op_count", cnt3, 0);
    chk("rst op_a", a3, 0);

    // 1: 5 + 7 + cin=1 -> 13
    sw_cin = 1'b1;
    entry(32'd5); chk("t1 state A->B", st1, 1);
    entry(32'd7); chk("t1 state B->OP", st1, 2);
    entry(32'd0); chk("t1 state OP->EXEC", st1, 3);
    idle(1);
    chk("t1 state DONE", st1, 4); chk("t1 res_value", res1, 13);
    chk("t1 res_co", rco1, 0); chk("t1 res_valid", rv1, 1); chk("t1 op_count", cnt1, 1);
    idle(3);

    // 2: out-of-range op codes, including the NUM_OPS boundary and a value with legal low bits
    entry(32'd5); entry(32'd7);
    entry(32'd9);    chk("t2 err after 9", err1, 1); chk("t2 state stays OP", st1, 2);
    chk("t2 op_code kept", code1, 0);
    entry(32'd8);    chk("t2 err after 8", err3, 1); chk("t2 state after 8", st3, 2);
    entry(32'h100);  chk("t2 err after 0x100", err1, 1); chk("t2 op_code after 0x100", code1, 0);
    entry(32'd0);    chk("t2 err cleared", err1, 0); chk("t2 state EXEC", st1, 3);
    idle(4);
    chk("t2 res_value", res1, 13); chk("t2 op_count", cnt3, 2);

    // 3: carry out of the top bit
    sw_cin = 1'b0;
    entry(32'hFFFF_FFFF); entry(32'd1); entry(32'd0);
    idle(4);
    chk("t3 res_value", res1, 0); chk("t3 res_co", rco1, 1);
    chk("t3 L3 res_value", res3, 0); chk("t3 L3 res_co", rco3, 1);

    // 4: entry during S_EXEC is dropped; ALU_LAT=3 captures on the 3rd edge
    entry(32'd1); entry(32'd2); entry(32'd0);
    entry(32'd42);
    chk("t4 L3 op_a unchanged", a3, 1); chk("t4 L3 still EXEC", st3, 3);
    chk("t4 L1 op_a unchanged", a1, 1); chk("t4 L1 DONE", st1, 4);
    idle(1);
    chk("t4 L3 EXEC at edge 2", st3, 3); chk("t4 L3 res_valid low", rv3, 0);
    idle(1);
    chk("t4 L3 DONE at edge 3", st3, 4); chk("t4 L3 res_value", res3, 3);
    chk("t4 L3 op_count", cnt3, 4); chk("t4 L1 op_count", cnt1, 4);
    idle(2);

    // 5: clear together with an entry in S_B
    entry(32'd10); chk("t5 in S_B", st1, 1);
    clear = 1'b1; entry(32'd99); clear = 1'b0;
    chk("t5 state", st1, 0); chk("t5 op_b kept", b1, 2);
    chk("t5 res_valid", rv1, 0); chk("t5 op_count", cnt1, 4);
    idle(2);

    // 6: chained entry from S_DONE
    entry(32'd4); entry(32'd6); entry(32'd0);
    idle(4);
    chk("t6 first res", res1, 10);
    entry(32'd3);
    chk("t6 op_a", a1, 3); chk("t6 res_valid", rv1, 0); chk("t6 state", st1, 1);
    entry(32'd4); entry(32'd0);
    idle(4);
    chk("t6 res_value", res1, 7); chk("t6 L3 res_value", res3, 7);
    chk("t6 op_count", cnt1, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
